// File: rtl/interrupt_priority_controller.sv
// Prioritised, nesting interrupt controller feeding the 6502 IRQB input.
// Eight register slots on a small CPU bus. Line 0 has the highest priority.
// Reading VECTOR acknowledges the best request. Writing EOI retires the
// current in-service level.
module interrupt_priority_controller #(
    parameter int unsigned NUM_IRQ    = 8,
    parameter logic [7:0]  RESET_MASK = 8'h00
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [7:0]         i_data,
    output logic [7:0]         o_data,
    input  logic               cs,
    input  logic               rwb,
    input  logic [2:0]         addr,
    input  logic [NUM_IRQ-1:0] irqb_in,
    output logic               irqb_master
);

    localparam logic [7:0] VALID     = 8'((9'd1 << NUM_IRQ) - 9'd1);
    localparam logic [2:0] A_PEND    = 3'd0;
    localparam logic [2:0] A_MASK    = 3'd1;
    localparam logic [2:0] A_EDGE    = 3'd2;
    localparam logic [2:0] A_ISR     = 3'd3;
    localparam logic [2:0] A_VECTOR  = 3'd4;
    localparam logic [2:0] A_EOI     = 3'd5;
    localparam logic [2:0] A_CTRL    = 3'd6;

    logic [NUM_IRQ-1:0] s1, s2, s3;
    logic               cs_q;
    logic [7:0]         pend, mask, edge_mode, isr;
    logic               ctrl_en;

    logic [7:0] pend_n, mask_n, edge_mode_n, isr_n, o_data_n;
    logic       ctrl_en_n, irqb_master_n;

    logic [7:0] low_now, new_edge, req, rd_val, w1c, ack_bit, eoi_bit;
    logic [2:0] best;
    logic [3:0] cur;
    logic       active, first, wr_first, ack, eoi;

    // Line state after synchronisation: current low level and fresh falling edges
    always_comb begin
        low_now  = VALID & ~8'(s2);
        new_edge = low_now & 8'(s3);
    end

    // Priority resolution: best enabled request against current service level
    always_comb begin
        req  = pend & mask;
        best = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (req[i]) best = 3'(i);
        end
        cur = 4'(NUM_IRQ);
        for (int i = 7; i >= 0; i--) begin
            if (isr[i]) cur = 4'(i);
        end
        active = ctrl_en && (req != 8'h00) && ({1'b0, best} < cur);
    end

    // Read data mux; VECTOR returns 0x80 when nothing can be acknowledged
    always_comb begin
        rd_val = 8'h00;
        case (addr)
            A_PEND:   rd_val = pend;
            A_MASK:   rd_val = mask;
            A_EDGE:   rd_val = edge_mode;
            A_ISR:    rd_val = isr;
            A_VECTOR: rd_val = active ? {5'b0, best} : 8'h80;
            A_CTRL:   rd_val = {7'b0, ctrl_en};
            default:  rd_val = 8'h00;
        endcase
    end

    // Next-state: bus side effects act only on the first cycle of an access
    always_comb begin
        first    = cs & ~cs_q;
        wr_first = first & ~rwb;
        ack      = first & rwb & (addr == A_VECTOR) & active;
        eoi      = wr_first & (addr == A_EOI) & (isr != 8'h00);
        w1c      = (wr_first && addr == A_PEND) ? (i_data & edge_mode) : 8'h00;
        ack_bit  = ack ? (8'd1 << best) : 8'h00;
        eoi_bit  = eoi ? (8'd1 << cur[2:0]) : 8'h00;

        // Edge lines latch and clear, a new edge beats a clear; level lines follow the pin
        pend_n = VALID & ((edge_mode & ((pend & ~(w1c | ack_bit)) | new_edge))
                        | (~edge_mode & low_now));
        isr_n  = (isr | ack_bit) & ~eoi_bit;

        mask_n      = mask;
        edge_mode_n = edge_mode;
        ctrl_en_n   = ctrl_en;
        if (wr_first) begin
            case (addr)
                A_MASK:  mask_n      = i_data & VALID;
                A_EDGE:  edge_mode_n = i_data & VALID;
                A_CTRL:  ctrl_en_n   = i_data[0];
                default: ;
            endcase
        end

        o_data_n      = (cs && rwb) ? rd_val : o_data;
        irqb_master_n = ~active;
    end

    // State registers with synchronous reset; synchroniser idles high
    always_ff @(posedge clk) begin
        if (reset) begin
            s1          <= '1;
            s2          <= '1;
            s3          <= '1;
            cs_q        <= 1'b0;
            pend        <= 8'h00;
            mask        <= RESET_MASK & VALID;
            edge_mode   <= 8'h00;
            isr         <= 8'h00;
            ctrl_en     <= 1'b0;
            o_data      <= 8'h00;
            irqb_master <= 1'b1;
        end else begin
            s1          <= irqb_in;
            s2          <= s1;
            s3          <= s2;
            cs_q        <= cs;
            pend        <= pend_n;
            mask        <= mask_n;
            edge_mode   <= edge_mode_n;
            isr         <= isr_n;
            ctrl_en     <= ctrl_en_n;
            o_data      <= o_data_n;
            irqb_master <= irqb_master_n;
        end
    end

endmodule

// File: tb/tb_interrupt_priority_controller.sv
// Directed and randomised bench for interrupt_priority_controller.
// A behavioural model keeps the in-service levels as a stack of line numbers.
module tb_interrupt_priority_controller;

    localparam int N = 8;

    logic         clk = 1'b0;
    logic         reset;
    logic [7:0]   i_data;
    logic [7:0]   o_data;
    logic         cs;
    logic         rwb;
    logic [2:0]   addr;
    logic [N-1:0] irqb_in;
    logic         irqb_master;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    interrupt_priority_controller #(.NUM_IRQ(N), .RESET_MASK(8'h00)) dut (
        .clk(clk), .reset(reset), .i_data(i_data), .o_data(o_data),
        .cs(cs), .rwb(rwb), .addr(addr), .irqb_in(irqb_in),
        .irqb_master(irqb_master)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%02h expected=%02h", tag, obs, exp);
        end
    endtask

    // Behavioural model, evaluated on each rising edge from pre-edge values
    logic [7:0] m_pend, m_mask, m_edge, m_o;
    bit         m_ctrl, m_irqb, m_csp;
    logic [7:0] m_samp[$];
    int         m_stack[$];

    always @(posedge clk) begin : model
        int best, cur;
        bit act, first, ack, w1c_hit;
        logic [7:0] rv, isrv, np, s2, s3;
        if (reset) begin
            m_samp  = '{8'hFF, 8'hFF, 8'hFF};
            m_pend  = 8'h00; m_mask = 8'h00; m_edge = 8'h00; m_o = 8'h00;
            m_ctrl  = 1'b0;  m_irqb = 1'b1;  m_csp  = 1'b0;
            m_stack.delete();
        end else begin
            first = cs && !m_csp;
            best  = -1;
            for (int i = 0; i < N; i++)
                if (best < 0 && m_pend[i] && m_mask[i]) best = i;
            cur  = (m_stack.size() == 0) ? N : m_stack[$];
            act  = m_ctrl && best >= 0 && best < cur;
            isrv = 8'h00;
            foreach (m_stack[k]) isrv[m_stack[k]] = 1'b1;
            case (addr)
                3'd0: rv = m_pend;
                3'd1: rv = m_mask;
                3'd2: rv = m_edge;
                3'd3: rv = isrv;
                3'd4: rv = act ? 8'(best) : 8'h80;
                3'd6: rv = {7'b0, m_ctrl};
                default: rv = 8'h00;
            endcase
            if (cs && rwb) m_o = rv;
            s2  = m_samp[1];
            s3  = m_samp[2];
            ack = first && rwb && addr == 3'd4 && act;
            for (int i = 0; i < N; i++) begin
                w1c_hit = first && !rwb && addr == 3'd0 && i_data[i];
                if (m_edge[i]) begin
                    if (!s2[i] && s3[i])                np[i] = 1'b1;
                    else if (w1c_hit || (ack && best == i)) np[i] = 1'b0;
                    else                                np[i] = m_pend[i];
                end else begin
                    np[i] = !s2[i];
                end
            end
            if (ack) m_stack.push_back(best);
            if (first && !rwb && addr == 3'd5 && m_stack.size() > 0) void'(m_stack.pop_back());
            if (first && !rwb) begin
                case (addr)
                    3'd1: m_mask = i_data;
                    3'd2: m_edge = i_data;
                    3'd6: m_ctrl = i_data[0];
                    default: ;
                endcase
            end
            m_pend = np;
            m_irqb = !act;
            m_samp.push_front(8'(irqb_in));
            void'(m_samp.pop_back());
            m_csp = cs;
        end
    end

    // Every falling edge the DUT outputs are compared against the model
    always @(negedge clk) begin
        if (chk_en) begin
            chk("model_o_data", o_data, m_o);
            chk("model_irqb", {7'b0, irqb_master}, {7'b0, m_irqb});
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic bus_wr(input logic [2:0] a, input logic [7:0] d);
        cs = 1'b1; rwb = 1'b0; addr = a; i_data = d;
        @(negedge clk);
        cs = 1'b0;
        @(negedge clk);
    endtask

    task automatic rd_chk(input string tag, input logic [2:0] a, input logic [7:0] exp);
        logic [7:0] d;
        cs = 1'b1; rwb = 1'b1; addr = a;
        @(negedge clk);
        d  = o_data;
        cs = 1'b0;
        @(negedge clk);
        chk(tag, d, exp);
    endtask

    task automatic pulse(input int line);
        irqb_in[line] = 1'b0;
        @(negedge clk);
        irqb_in[line] = 1'b1;
    endtask

    task automatic do_reset();
        reset = 1'b1; cs = 1'b0; irqb_in = '1;
        idle(2);
        reset = 1'b0;
    endtask

    task automatic setup(input logic [7:0] m, input logic [7:0] e, input logic [7:0] c);
        bus_wr(3'd1, m);
        bus_wr(3'd2, e);
        bus_wr(3'd6, c);
    endtask

    initial begin
        reset = 1'b1; cs = 1'b0; rwb = 1'b1; addr = 3'd0; i_data = 8'h00; irqb_in = '1;
        idle(2);
        chk("reset_o_data", o_data, 8'h00);
        chk("reset_irqb", {7'b0, irqb_master}, 8'h01);
        chk_en = 1'b1;
        reset  = 1'b0;

        // 1: single edge request, latency, acknowledge
        setup(8'h01, 8'h01, 8'h01);
        irqb_in[0] = 1'b0;
        @(negedge clk);
        irqb_in[0] = 1'b1;
        idle(2);
        chk("t1_lat_k2", {7'b0, irqb_master}, 8'h01);
        idle(1);
        chk("t1_lat_k3", {7'b0, irqb_master}, 8'h00);
        rd_chk("t1_pend", 3'd0, 8'h01);
        rd_chk("t1_vector", 3'd4, 8'h00);
        chk("t1_deassert", {7'b0, irqb_master}, 8'h01);
        rd_chk("t1_isr", 3'd3, 8'h01);
        rd_chk("t1_pend_clr", 3'd0, 8'h00);

        // 2: nesting and retirement
        do_reset();
        setup(8'hFF, 8'hFF, 8'h01);
        pulse(5); idle(4);
        rd_chk("t2_vec5", 3'd4, 8'h05);
        pulse(2); idle(4);
        chk("t2_nest_irq", {7'b0, irqb_master}, 8'h00);
        rd_chk("t2_vec2", 3'd4, 8'h02);
        rd_chk("t2_isr24", 3'd3, 8'h24);
        pulse(6); idle(4);
        chk("t2_low_prio", {7'b0, irqb_master}, 8'h01);
        bus_wr(3'd5, 8'h00);
        rd_chk("t2_isr20", 3'd3, 8'h20);
        bus_wr(3'd5, 8'h00);
        rd_chk("t2_isr0", 3'd3, 8'h00);
        chk("t2_line6_irq", {7'b0, irqb_master}, 8'h00);
        rd_chk("t2_vec6", 3'd4, 8'h06);

        // 3: level-sensitive line
        do_reset();
        setup(8'h08, 8'h00, 8'h01);
        irqb_in[3] = 1'b0; idle(4);
        chk("t3_level_irq", {7'b0, irqb_master}, 8'h00);
        bus_wr(3'd0, 8'h08);
        rd_chk("t3_pend_w1c", 3'd0, 8'h08);
        rd_chk("t3_vec3", 3'd4, 8'h03);
        chk("t3_in_service", {7'b0, irqb_master}, 8'h01);
        irqb_in[3] = 1'b1; idle(3);
        bus_wr(3'd5, 8'h00); idle(3);
        chk("t3_after_eoi", {7'b0, irqb_master}, 8'h01);
        rd_chk("t3_pend0", 3'd0, 8'h00);

        // 4: spurious vector, empty EOI, held chip select
        do_reset();
        setup(8'hFF, 8'hFF, 8'h01);
        rd_chk("t4_spurious", 3'd4, 8'h80);
        rd_chk("t4_isr_spur", 3'd3, 8'h00);
        bus_wr(3'd5, 8'h00);
        rd_chk("t4_isr_eoi", 3'd3, 8'h00);
        irqb_in[1] = 1'b0; irqb_in[4] = 1'b0;
        @(negedge clk);
        irqb_in = '1; idle(4);
        cs = 1'b1; rwb = 1'b1; addr = 3'd4;
        idle(4);
        cs = 1'b0; idle(1);
        rd_chk("t4_single_ack", 3'd3, 8'h02);

        // 5: set beats W1C, global enable gating
        do_reset();
        setup(8'h00, 8'hFF, 8'h01);
        pulse(1); idle(4);
        rd_chk("t5_pend_pre", 3'd0, 8'h02);
        irqb_in[1] = 1'b0;
        @(negedge clk);
        irqb_in[1] = 1'b1;
        bus_wr(3'd0, 8'h02);
        rd_chk("t5_set_wins", 3'd0, 8'h02);
        bus_wr(3'd0, 8'h02);
        rd_chk("t5_w1c", 3'd0, 8'h00);
        bus_wr(3'd6, 8'h00);
        bus_wr(3'd1, 8'h02);
        pulse(1); idle(4);
        chk("t5_ctrl_off", {7'b0, irqb_master}, 8'h01);
        bus_wr(3'd6, 8'h01);
        chk("t5_ctrl_on", {7'b0, irqb_master}, 8'h00);

        // 6: reset in the middle of service with bus activity
        do_reset();
        setup(8'hFF, 8'hFF, 8'h01);
        pulse(5); idle(4);
        rd_chk("t6_vec5", 3'd4, 8'h05);
        pulse(2); idle(4);
        chk("t6_pre_irq", {7'b0, irqb_master}, 8'h00);
        reset = 1'b1; cs = 1'b1; rwb = 1'b0; addr = 3'd1; i_data = 8'hFF;
        @(negedge clk);
        chk("t6_rst_irqb", {7'b0, irqb_master}, 8'h01);
        chk("t6_rst_odata", o_data, 8'h00);
        reset = 1'b0; cs = 1'b0;
        idle(1);
        rd_chk("t6_pend", 3'd0, 8'h00);
        rd_chk("t6_mask", 3'd1, 8'h00);
        rd_chk("t6_edge", 3'd2, 8'h00);
        rd_chk("t6_isr", 3'd3, 8'h00);
        rd_chk("t6_ctrl", 3'd6, 8'h00);

        // Randomised traffic, checked cycle by cycle against the model
        do_reset();
        setup(8'hFF, 8'hF0, 8'h01);
        for (int c = 0; c < 3000; c++) begin
            reset = ($urandom_range(0, 399) == 0);
            for (int b = 0; b < N; b++)
                if ($urandom_range(0, 9) == 0) irqb_in[b] = ~irqb_in[b];
            cs     = ($urandom_range(0, 2) == 0);
            rwb    = 1'($urandom_range(0, 1));
            addr   = ($urandom_range(0, 2) == 0) ? 3'd4 : 3'($urandom_range(0, 7));
            i_data = 8'($urandom);
            @(negedge clk);
        end
        reset = 1'b0; cs = 1'b0;
        idle(2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
